// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: DATA_BITS data bits sent LSB first, optional even/odd
// parity, and 1 or 2 stop bits. Bit timing comes from an oversampled baud tick.
module uart_tx_cfg #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_sample_tick,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] byte_to_send,
  input  logic [1:0]           parity_mode,
  input  logic                 two_stop,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic [2:0]           state_dbg
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // Handshake: a request is accepted on any clk edge where tx_start=1 and the
  // transmitter is idle; tx_busy covers acceptance through the final stop bit,
  // and tx_done pulses for one cycle on the same edge tx_busy falls.

  state_t                 state, state_n;
  logic [TW-1:0]          tick_cnt, tick_n;
  logic [BW-1:0]          bit_cnt, bit_n;
  logic [DATA_BITS-1:0]   shift_reg, shift_n;
  logic [DATA_BITS-1:0]   data_q, data_n;
  logic [1:0]             pmode_q, pmode_n;
  logic                   two_stop_q, two_stop_n;
  logic                   tx_q, tx_n;
  logic                   busy_q, busy_n;
  logic                   done_q, done_n;

  logic bit_end;
  logic par_en;
  logic par_bit;

  assign bit_end = baud_sample_tick && (tick_cnt == TICK_LAST);
  assign par_en  = (pmode_q == 2'b01) || (pmode_q == 2'b10);
  // Parity comes from the latched word because shift_reg is consumed during DATA.
  assign par_bit = (pmode_q == 2'b10) ? ~(^data_q) : (^data_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      data_q     <= '0;
      pmode_q    <= 2'b00;
      two_stop_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state      <= state_n;
      tick_cnt   <= tick_n;
      bit_cnt    <= bit_n;
      shift_reg  <= shift_n;
      data_q     <= data_n;
      pmode_q    <= pmode_n;
      two_stop_q <= two_stop_n;
      tx_q       <= tx_n;
      busy_q     <= busy_n;
      done_q     <= done_n;
    end
  end

  always_comb begin
    state_n    = state;
    tick_n     = tick_cnt;
    bit_n      = bit_cnt;
    shift_n    = shift_reg;
    data_n     = data_q;
    pmode_n    = pmode_q;
    two_stop_n = two_stop_q;
    tx_n       = tx_q;
    busy_n     = busy_q;
    done_n     = 1'b0;

    if (state != IDLE && baud_sample_tick) begin
      tick_n = bit_end ? '0 : tick_cnt + TW'(1);
    end

    // tx_n is the value the line will hold during the next bit, so tx stays a flop.
    case (state)
      IDLE: begin
        tx_n   = 1'b1;
        busy_n = 1'b0;
        if (tx_start) begin
          data_n     = byte_to_send;
          shift_n    = byte_to_send;
          pmode_n    = parity_mode;
          two_stop_n = two_stop;
          state_n    = START;
          tx_n       = 1'b0;
          busy_n     = 1'b1;
          tick_n     = '0;
          bit_n      = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_n = DATA;
          tx_n    = shift_reg[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_n = shift_reg >> 1;
          if (bit_cnt == BIT_LAST) begin
            bit_n = '0;
            if (par_en) begin
              state_n = PARITY;
              tx_n    = par_bit;
            end else begin
              state_n = STOP;
              tx_n    = 1'b1;
            end
          end else begin
            bit_n = bit_cnt + BW'(1);
            tx_n  = shift_reg[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_n = STOP;
          tx_n    = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          // bit_cnt marks that the first of two stop bits has already gone out.
          if (two_stop_q && bit_cnt == '0) begin
            bit_n = BW'(1);
          end else begin
            state_n = IDLE;
            bit_n   = '0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end

  assign tx        = tx_q;
  assign tx_busy   = busy_q;
  assign tx_done   = done_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: a default instance and a DATA_BITS=7/OVERSAMPLE=8 instance,
// each frame compared tick by tick against a bit list built from the frame format.
module tb_uart_tx_cfg;

  localparam int TICK_DIV = 4;

  // clock / reset / tick
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       baud_sample_tick = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] byte_to_send = 8'h00;
  logic [1:0] parity_mode = 2'b00;
  logic       two_stop = 1'b0;
  logic       sel_b = 1'b0;
  int         tdiv = 0;

  initial forever #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      tdiv = tdiv + 1;
      baud_sample_tick = (tdiv % TICK_DIV == 0);
    end
  end

  logic       start_a, start_b;
  logic       tx_a, busy_a, done_a, tx_b, busy_b, done_b;
  logic [2:0] st_a, st_b;
  logic       o_tx, o_busy, o_done;

  assign start_a = tx_start & ~sel_b;
  assign start_b = tx_start & sel_b;
  assign o_tx    = sel_b ? tx_b : tx_a;
  assign o_busy  = sel_b ? busy_b : busy_a;
  assign o_done  = sel_b ? done_b : done_a;

  uart_tx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16)) dut_a (
    .clk(clk), .rst(rst), .baud_sample_tick(baud_sample_tick), .tx_start(start_a),
    .byte_to_send(byte_to_send), .parity_mode(parity_mode), .two_stop(two_stop),
    .tx(tx_a), .tx_busy(busy_a), .tx_done(done_a), .state_dbg(st_a)
  );

  uart_tx_cfg #(.DATA_BITS(7), .OVERSAMPLE(8)) dut_b (
    .clk(clk), .rst(rst), .baud_sample_tick(baud_sample_tick), .tx_start(start_b),
    .byte_to_send(byte_to_send[6:0]), .parity_mode(parity_mode), .two_stop(two_stop),
    .tx(tx_b), .tx_busy(busy_b), .tx_done(done_b), .state_dbg(st_b)
  );

  // scoreboard
  int         checks = 0;
  int         failures = 0;
  int         frames = 0;
  logic [0:0] cap_q[$];
  logic [0:0] frame_q[$];
  logic [0:0] exp_q[$];
  logic       prev_done = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Line value seen at every baud tick while busy; a frame closes on tx_done.
  always @(negedge clk) begin
    if (!rst) begin
      cap_q.delete();
    end else begin
      if (o_busy && baud_sample_tick) cap_q.push_back(o_tx);
      if (prev_done) check_eq("done_pulse_width", {31'd0, o_done}, 0);
      if (o_done) begin
        check_eq("done_busy_low", {31'd0, o_busy}, 0);
        check_eq("done_tx_high", {31'd0, o_tx}, 1);
        frame_q = cap_q;
        cap_q.delete();
        frames++;
      end
    end
    prev_done = o_done;
  end

  // Reference: frame as a list of serial bits, each held for os ticks.
  task automatic build_exp(input logic [7:0] data, input logic [1:0] pm, input logic ts,
                           input int db, input int os, output int nbits);
    int   ones;
    logic bits[$];
    ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < db; i++) begin
      bits.push_back(data[i]);
      if (data[i]) ones++;
    end
    if (pm == 2'b01) bits.push_back(1'(ones % 2));
    if (pm == 2'b10) bits.push_back(1'(1 - ones % 2));
    bits.push_back(1'b1);
    if (ts) bits.push_back(1'b1);
    nbits = bits.size();
    exp_q.delete();
    for (int k = 0; k < nbits; k++)
      for (int j = 0; j < os; j++) exp_q.push_back(bits[k]);
  endtask

  task automatic compare_frame(input logic [7:0] data, input logic [1:0] pm, input logic ts,
                               input int db, input int os);
    int          nbits;
    logic [31:0] obs;
    logic [31:0] exp;
    build_exp(data, pm, ts, db, os, nbits);
    check_eq($sformatf("frame_len d=%0h pm=%0d ts=%0d", data, pm, ts), frame_q.size(), exp_q.size());
    for (int k = 0; k < nbits; k++) begin
      exp = {31'd0, exp_q[k*os]};
      obs = exp;
      for (int j = 0; j < os; j++) begin
        if (k*os + j >= frame_q.size()) obs = 2;
        else if (frame_q[k*os + j] !== exp_q[k*os + j]) obs = {31'd0, frame_q[k*os + j]};
      end
      check_eq($sformatf("bit%0d d=%0h pm=%0d", k, data, pm), obs, exp);
    end
  endtask

  // driver
  task automatic send_frame(input logic [7:0] data, input logic [1:0] pm, input logic ts);
    int os, db, f0, len, n;
    os  = sel_b ? 8 : 16;
    db  = sel_b ? 7 : 8;
    f0  = frames;
    len = os * (2 + db + ((pm == 2'b01 || pm == 2'b10) ? 1 : 0) + (ts ? 1 : 0));
    n   = 0;
    @(posedge clk); #1;
    byte_to_send = data;
    parity_mode  = pm;
    two_stop     = ts;
    tx_start     = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0;
    check_eq("accept_busy", {31'd0, o_busy}, 1);
    check_eq("accept_tx", {31'd0, o_tx}, 0);
    byte_to_send = 8'($urandom);
    parity_mode  = 2'($urandom);
    two_stop     = 1'($urandom);
    while (frames == f0 && n < 20000) begin
      @(posedge clk); #1;
      n++;
      tx_start = (cap_q.size() < len - os) && ($urandom_range(0, 7) == 0);
    end
    tx_start = 1'b0;
    check_eq("frame_done", frames, f0 + 1);
    compare_frame(data, pm, ts, db, os);
    repeat (3) @(posedge clk);
    #1;
    check_eq("start_not_queued", {31'd0, o_busy}, 0);
  endtask

  task automatic wait_frames(input int target);
    int n;
    n = 0;
    while (frames < target && n < 20000) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    int f0;
    int n;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_tx_a", {31'd0, tx_a}, 1);
    check_eq("rst_busy_a", {31'd0, busy_a}, 0);
    check_eq("rst_done_a", {31'd0, done_a}, 0);
    check_eq("rst_tx_b", {31'd0, tx_b}, 1);
    check_eq("rst_busy_b", {31'd0, busy_b}, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    send_frame(8'hA5, 2'b00, 1'b0);
    send_frame(8'hA5, 2'b01, 1'b0);
    send_frame(8'hA5, 2'b10, 1'b0);
    send_frame(8'h3C, 2'b00, 1'b1);

    // back-to-back with tx_start held high
    f0 = frames;
    @(posedge clk); #1;
    byte_to_send = 8'h01; parity_mode = 2'b00; two_stop = 1'b0; tx_start = 1'b1;
    @(posedge clk); #1;
    check_eq("b2b_accept", {31'd0, o_busy}, 1);
    byte_to_send = 8'h80;
    wait_frames(f0 + 1);
    check_eq("b2b_first_done", frames, f0 + 1);
    check_eq("b2b_gap_busy", {31'd0, o_busy}, 1);
    check_eq("b2b_gap_tx", {31'd0, o_tx}, 0);
    compare_frame(8'h01, 2'b00, 1'b0, 8, 16);
    tx_start = 1'b0;
    wait_frames(f0 + 2);
    check_eq("b2b_second_done", frames, f0 + 2);
    compare_frame(8'h80, 2'b00, 1'b0, 8, 16);
    repeat (3) @(posedge clk);

    // abort during DATA
    f0 = frames;
    n = 0;
    @(posedge clk); #1;
    byte_to_send = 8'hC3; parity_mode = 2'b01; two_stop = 1'b0; tx_start = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0;
    while (cap_q.size() < 16 * 3 && n < 20000) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check_eq("abort_tx_high", {31'd0, tx_a}, 1);
    check_eq("abort_busy_low", {31'd0, busy_a}, 0);
    check_eq("abort_done_low", {31'd0, done_a}, 0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("abort_no_done", frames, f0);
    rst = 1'b1;
    send_frame(8'h5A, 2'b00, 1'b0);

    for (int i = 0; i < 6; i++)
      send_frame(8'($urandom), 2'($urandom_range(0, 3)), 1'($urandom));

    sel_b = 1'b1;
    send_frame(8'h55, 2'b10, 1'b0);
    for (int i = 0; i < 3; i++)
      send_frame(8'($urandom), 2'($urandom_range(0, 3)), 1'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
- Parametrised successor to the fixed 8N1 UART transmitter.
- Serialises a DATA_BITS-wide word, LSB first, with run-time selectable parity (none/even/odd) and 1 or 2 stop bits.
- Bit timing is derived from an external oversampled baud tick, the same tick source the receiver uses.
- Sits between the host-side byte interface and the serial pin, with a start/busy/done handshake.

Parameters:
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- OVERSAMPLE, 16, baud_sample_tick pulses per serial bit period; legal range 4..64.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous reset, active-low: rst=0 resets immediately; release is synchronous to clk.
- baud_sample_tick  in  1  one-clk-wide enable pulse at OVERSAMPLE x baud rate.
- tx_start  in  1  request to send; sampled on clk edges while tx_busy=0.
- byte_to_send  in  DATA_BITS  word to transmit; captured when the request is accepted.
- parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none; captured when the request is accepted.
- two_stop  in  1  0 = one stop bit, 1 = two stop bits; captured when the request is accepted.
- tx  out  1  serial line, idle high.
- tx_busy  out  1  high from acceptance until the frame completes.
- tx_done  out  1  one-clk pulse on frame completion.

Behaviour:
- Reset values: tx=1, tx_busy=0, tx_done=0, state=IDLE, all counters 0.
- Reset asserted mid-frame aborts the frame: tx returns high asynchronously and no tx_done is produced.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1.
  - If tx_start=1 on a clk edge, next cycle: latch byte_to_send, parity_mode and two_stop; state=START; tx=0; tx_busy=1; tick_cnt=0; bit_cnt=0.
  - Acceptance latency is 1 clk. It does not wait for a baud tick.
- Bit duration:
  - Every non-IDLE state advances tick_cnt only on baud_sample_tick=1.
  - When tick_cnt=OVERSAMPLE-1 and a tick arrives, the bit ends: tick_cnt wraps to 0 and the state/bit advances.
  - Each bit therefore lasts exactly OVERSAMPLE ticks, measured from the first tick after entry.
- START: tx=0 for one bit, then go to DATA.
- DATA:
  - tx=shift_reg[0]; shift right at each bit end.
  - bit_cnt counts 0..DATA_BITS-1.
  - After bit DATA_BITS-1, go to PARITY if the latched mode is even or odd, else go to STOP.
- PARITY:
  - Even mode: tx = XOR of the latched data bits.
  - Odd mode: tx = inverted XOR of the latched data bits.
  - Parity is computed from the latched word, not from the shifting register.
  - Lasts one bit, then go to STOP.
- STOP:
  - tx=1 for 1 bit, or 2 bits if the latched two_stop=1.
  - At the end of the final stop bit, in one edge: state=IDLE, tx_busy=0, tx_done=1 for one cycle.
- Back-to-back frames:
  - tx_start held high while tx_done=1 is accepted on the following edge (IDLE, busy=0).
  - The gap between frames is therefore 1 clk plus tick alignment; no extra idle bit is inserted.
- tx_start while tx_busy=1 is ignored and not queued.
- Changes on byte_to_send, parity_mode or two_stop during a frame have no effect on that frame.
- Frame length = OVERSAMPLE x (1 + DATA_BITS + P + S) ticks, where P = 0 or 1 and S = 1 or 2.
- Counter widths: tick_cnt uses clog2(OVERSAMPLE) bits; bit_cnt uses clog2(DATA_BITS+1) bits. No counter may overflow at the parameter extremes.
- tx is registered: no combinational path from any input to tx.

Test Plan:
- Defaults, 0xA5, parity none, one stop, tick every 4 clk:
  - Line reads 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop).
  - Each bit lasts 16 ticks; tx_busy is high for 160 ticks.
  - Exactly one tx_done pulse; tx_busy falls on the same edge.
- 0xA5 with even parity then odd parity:
  - Parity bit is 0 (even) and 1 (odd).
  - Frame length is 176 ticks in both cases.
- 0x3C with two_stop=1 and parity none:
  - Two high stop bits; frame length 176 ticks.
  - byte_to_send changed to 0xFF mid-frame does not alter the transmitted bits.
- Hold tx_start=1 continuously with 0x01 then 0x80:
  - Second frame's start bit begins within 1 clk plus one tick of the first tx_done.
  - tx_start pulses sent during the busy period are not queued.
- Assert rst=0 during the DATA state of frame 1:
  - tx=1 and tx_busy=0 immediately with no clk edge; no tx_done.
  - After release, a new 0x5A frame transmits correctly.
- Recompile with DATA_BITS=7, OVERSAMPLE=8, send 0x55 with odd parity:
  - Bits are 0,1,0,1,0,1,0,1,(parity)1,(stop)1.
  - Each bit lasts 8 ticks; frame length 80 ticks.
